// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the 2-way, 64-set cache metadata controller:
// geometry constants, metadata byte layout, address field helpers and the
// controller state encoding.
// -----------------------------------------------------------------------------
package cache_pkg;

   localparam int SETS   = 64;
   localparam int WORDS  = 8;
   localparam int IDX_W  = 6;
   localparam int TAG_W  = 6;
   localparam int WORD_W = 3;

   // Metadata byte layout: {valid, victim pointer, tag[5:0]}
   localparam int META_VALID = 7;
   localparam int META_LRU   = 6;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      HIT_UPD,
      INVAL,
      FILL,
      META_WR,
      LRU_WR
   } state_e;

   // Byte address: tag=[15:10], index=[9:4], offset=[3:0]
   function automatic logic [TAG_W-1:0] addr_tag(input logic [15:0] addr);
      return addr[15:10];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [15:0] addr);
      return addr[9:4];
   endfunction

   function automatic logic [7:0] meta_byte(input logic valid, input logic lru,
                                            input logic [TAG_W-1:0] tag);
      return {valid, lru, tag};
   endfunction

endpackage

// File: rtl/cache_meta_ctrl_if.sv
// -----------------------------------------------------------------------------
// cache_meta_ctrl_if
// Bundles every bus the controller touches: the request/response pair toward
// the fetch stage, the metadata array port, the memory read port and the
// data-array write port.
//   master : the controller (drives strobes, addresses, responses)
//   slave  : the surrounding pipeline, arrays and memory
// -----------------------------------------------------------------------------
interface cache_meta_ctrl_if;

   // request / response
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_addr;
   logic        resp_valid;
   logic        resp_hit;
   logic        resp_way;

   // metadata array (one byte per way, shared write byte, per-way strobes)
   logic [63:0] meta_block_enable;
   logic        meta_write0;
   logic        meta_write1;
   logic [7:0]  meta_data_in;
   logic [7:0]  meta_out0;
   logic [7:0]  meta_out1;

   // memory read port
   logic        mem_en;
   logic [15:0] mem_addr;
   logic        mem_data_valid;
   logic [15:0] mem_data;

   // data array write port
   logic        data_write;
   logic        data_way;
   logic [2:0]  data_word;
   logic [15:0] data_wdata;

   modport master (
      input  req_valid, req_addr, meta_out0, meta_out1, mem_data_valid, mem_data,
      output req_ready, resp_valid, resp_hit, resp_way,
             meta_block_enable, meta_write0, meta_write1, meta_data_in,
             mem_en, mem_addr, data_write, data_way, data_word, data_wdata
   );

   modport slave (
      output req_valid, req_addr, meta_out0, meta_out1, mem_data_valid, mem_data,
      input  req_ready, resp_valid, resp_hit, resp_way,
             meta_block_enable, meta_write0, meta_write1, meta_data_in,
             mem_en, mem_addr, data_write, data_way, data_word, data_wdata
   );

endinterface

// File: rtl/cache_victim_sel.sv
// -----------------------------------------------------------------------------
// cache_victim_sel
// Chooses the way to evict on a miss: an invalid way 0 first, then an invalid
// way 1, otherwise whatever the victim pointer held in way 0 names.
//   i_v0   : way 0 valid bit
//   i_lru0 : way 0 victim pointer
//   i_v1   : way 1 valid bit
//   o_way  : selected victim way
// -----------------------------------------------------------------------------
module cache_victim_sel (
   input  logic i_v0,
   input  logic i_lru0,
   input  logic i_v1,
   output logic o_way
);

   assign o_way = !i_v0 ? 1'b0 :
                  !i_v1 ? 1'b1 :
                          i_lru0;

endmodule

// File: rtl/cache_meta_ctrl.sv
// -----------------------------------------------------------------------------
// cache_meta_ctrl
// Lookup and miss-fill controller for a 2-way, 64-set cache. Reads both
// metadata ways, resolves hit/miss, invalidates the victim before refilling
// it with an 8-word block from memory, then writes back tag, valid and the
// victim pointer (kept in way 0 only).
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   io_bus : request/response, metadata, memory and data-array buses
// -----------------------------------------------------------------------------
module cache_meta_ctrl
   import cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   cache_meta_ctrl_if.master  io_bus
);

   state_e             r_state, w_next;
   logic [TAG_W-1:0]   r_tag;
   logic [IDX_W-1:0]   r_idx;
   // Only way 0's valid and tag are needed after LOOKUP: they are written
   // back unchanged when way 1 becomes most recently used.
   logic               r_m0_valid;
   logic [TAG_W-1:0]   r_m0_tag;
   logic               r_way;        // hit way on a hit, victim way on a miss
   logic [WORD_W-1:0]  r_req_cnt;
   logic               r_req_done;   // all 8 words issued; req_cnt has wrapped
   logic [WORD_W-1:0]  r_ret_cnt;

   logic               w_hit0, w_hit1, w_victim;
   logic [7:0]         w_m0_keep;

   assign w_hit0 = io_bus.meta_out0[META_VALID] && (io_bus.meta_out0[TAG_W-1:0] == r_tag);
   assign w_hit1 = io_bus.meta_out1[META_VALID] && (io_bus.meta_out1[TAG_W-1:0] == r_tag);
   assign w_m0_keep = meta_byte(r_m0_valid, 1'b0, r_m0_tag);

   cache_victim_sel u_victim_sel (
      .i_v0   (io_bus.meta_out0[META_VALID]),
      .i_lru0 (io_bus.meta_out0[META_LRU]),
      .i_v1   (io_bus.meta_out1[META_VALID]),
      .o_way  (w_victim)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_tag      <= '0;
         r_idx      <= '0;
         r_m0_valid <= 1'b0;
         r_m0_tag   <= '0;
         r_way      <= 1'b0;
         r_req_cnt  <= '0;
         r_req_done <= 1'b0;
         r_ret_cnt  <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (io_bus.req_valid) begin
                  r_tag <= addr_tag(io_bus.req_addr);
                  r_idx <= addr_idx(io_bus.req_addr);
               end
            end
            LOOKUP: begin
               r_m0_valid <= io_bus.meta_out0[META_VALID];
               r_m0_tag   <= io_bus.meta_out0[TAG_W-1:0];
               // Way 0 wins when both ways hit.
               r_way      <= w_hit0 ? 1'b0 : (w_hit1 ? 1'b1 : w_victim);
            end
            INVAL: begin
               r_req_cnt  <= '0;
               r_req_done <= 1'b0;
               r_ret_cnt  <= '0;
            end
            FILL: begin
               if (!r_req_done) begin
                  r_req_cnt <= r_req_cnt + 3'd1;
                  if (r_req_cnt == 3'd7) r_req_done <= 1'b1;
               end
               // Issue and return may fall in the same cycle; both advance.
               if (io_bus.mem_data_valid) r_ret_cnt <= r_ret_cnt + 3'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case statement can infer a latch.
      w_next                   = r_state;
      io_bus.req_ready         = 1'b0;
      io_bus.resp_valid        = 1'b0;
      io_bus.resp_hit          = 1'b0;
      io_bus.resp_way          = 1'b0;
      io_bus.meta_block_enable = '0;
      io_bus.meta_write0       = 1'b0;
      io_bus.meta_write1       = 1'b0;
      io_bus.meta_data_in      = '0;
      io_bus.mem_en            = 1'b0;
      io_bus.mem_addr          = '0;
      io_bus.data_write        = 1'b0;
      io_bus.data_way          = 1'b0;
      io_bus.data_word         = '0;
      io_bus.data_wdata        = '0;

      if (r_state != IDLE) io_bus.meta_block_enable = 64'd1 << r_idx;

      case (r_state)
         IDLE: begin
            io_bus.req_ready = 1'b1;
            if (io_bus.req_valid) w_next = LOOKUP;
         end
         LOOKUP: begin
            w_next = (w_hit0 || w_hit1) ? HIT_UPD : INVAL;
         end
         HIT_UPD: begin
            io_bus.meta_write0  = 1'b1;
            io_bus.meta_data_in = r_way ? w_m0_keep : meta_byte(1'b1, 1'b1, r_tag);
            io_bus.resp_valid   = 1'b1;
            io_bus.resp_hit     = 1'b1;
            io_bus.resp_way     = r_way;
            w_next              = IDLE;
         end
         INVAL: begin
            // Victim goes invalid before any data word is overwritten.
            io_bus.meta_write0 = !r_way;
            io_bus.meta_write1 = r_way;
            w_next             = FILL;
         end
         FILL: begin
            io_bus.mem_en = !r_req_done;
            if (!r_req_done) io_bus.mem_addr = {r_tag, r_idx, r_req_cnt, 1'b0};
            if (io_bus.mem_data_valid) begin
               io_bus.data_write = 1'b1;
               io_bus.data_way   = r_way;
               io_bus.data_word  = r_ret_cnt;
               io_bus.data_wdata = io_bus.mem_data;
               if (r_ret_cnt == 3'd7) w_next = META_WR;
            end
         end
         META_WR: begin
            if (!r_way) begin
               io_bus.meta_write0  = 1'b1;
               io_bus.meta_data_in = meta_byte(1'b1, 1'b1, r_tag);
               io_bus.resp_valid   = 1'b1;
               w_next              = IDLE;
            end else begin
               io_bus.meta_write1  = 1'b1;
               io_bus.meta_data_in = meta_byte(1'b1, 1'b0, r_tag);
               w_next              = LRU_WR;
            end
         end
         LRU_WR: begin
            io_bus.meta_write0  = 1'b1;
            io_bus.meta_data_in = w_m0_keep;
            io_bus.resp_valid   = 1'b1;
            io_bus.resp_way     = 1'b1;
            w_next              = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_meta_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_meta_ctrl
// Self-checking bench for cache_meta_ctrl. Models the metadata array, the
// data array and an in-order memory with configurable latency and gaps.
// A set-level reference model (valid/tag per way plus a replacement pointer)
// predicts each response; a separate monitor compares responses, metadata
// bytes and filled data against the predictions.
// -----------------------------------------------------------------------------
module tb_cache_meta_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cache_meta_ctrl_if bus ();

   cache_meta_ctrl dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- metadata array model ----------------
   logic [7:0] meta_arr [2][64] = '{default: 8'h00};
   logic [5:0] sel_idx;
   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < 64; i++) if (bus.meta_block_enable[i]) sel_idx = 6'(i);
   end
   assign bus.meta_out0 = bus.meta_write0 ? 8'hzz : meta_arr[0][sel_idx];
   assign bus.meta_out1 = bus.meta_write1 ? 8'hzz : meta_arr[1][sel_idx];
   always @(posedge clk) begin
      if (bus.meta_write0) meta_arr[0][sel_idx] <= bus.meta_data_in;
      if (bus.meta_write1) meta_arr[1][sel_idx] <= bus.meta_data_in;
   end

   // ---------------- data array model ----------------
   logic [15:0] data_arr [2][64][8];
   int total_wr = 0;
   always @(posedge clk) begin
      if (bus.data_write) begin
         data_arr[bus.data_way][sel_idx][bus.data_word] <= bus.data_wdata;
         total_wr <= total_wr + 1;
      end
   end

   // ---------------- memory model ----------------
   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3A5;
   endfunction

   typedef struct { logic [15:0] addr; int ready; } mreq_t;
   mreq_t pend[$];
   int mem_lat  = 4;
   bit mem_gaps = 1'b0;

   initial begin
      mreq_t m;
      bus.mem_data_valid = 1'b0;
      bus.mem_data       = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            pend.delete();
            bus.mem_data_valid = 1'b0;
            bus.mem_data       = '0;
         end else begin
            if (bus.mem_en) begin
               m.addr  = bus.mem_addr;
               m.ready = cyc + mem_lat;
               pend.push_back(m);
            end
            bus.mem_data_valid = 1'b0;
            bus.mem_data       = 16'($urandom);
            if (pend.size() > 0) begin
               if (pend[0].ready <= cyc && !(mem_gaps && $urandom_range(0, 2) == 0)) begin
                  m = pend.pop_front();
                  bus.mem_data_valid = 1'b1;
                  bus.mem_data       = mem_fn(m.addr);
               end
            end else if ($urandom_range(0, 7) == 0) begin
               // stray return while no fill is waiting; must be ignored
               bus.mem_data_valid = 1'b1;
            end
         end
      end
   end

   // ---------------- reference model (set level) ----------------
   bit         m_v   [2][64];
   logic [5:0] m_t   [2][64];
   bit         m_ptr [64];     // 1 = way 0 most recently used, evict way 1

   function automatic logic [7:0] exp_byte0(input int s);
      return {m_v[0][s], m_ptr[s], m_t[0][s]};
   endfunction
   function automatic logic [7:0] exp_byte1(input int s);
      return {m_v[1][s], 1'b0, m_t[1][s]};
   endfunction

   typedef struct {
      logic [15:0] addr;
      bit          hit;
      bit          way;
      int          due;      // absolute response cycle, -1 when not fixed
      int          wr_base;
      logic [7:0]  b0;
      logic [7:0]  b1;
   } exp_t;
   exp_t sb[$];

   function automatic logic [127:0] outs();
      return 128'({bus.req_ready, bus.resp_valid, bus.resp_hit, bus.resp_way,
                   bus.meta_write0, bus.meta_write1, bus.meta_data_in,
                   bus.mem_en, bus.mem_addr, bus.data_write, bus.data_way,
                   bus.data_word, bus.data_wdata, bus.meta_block_enable});
   endfunction
   localparam logic [127:0] RST_OUTS = 128'(1) << 115;

   task automatic wait_ready(output bit ok);
      int guard = 0;
      @(negedge clk);
      while (!bus.req_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      ok = bus.req_ready;
      if (!ok) check("req_ready_timeout", bus.req_ready, 1'b1);
   endtask

   // Predicts the access, pushes the expectation, then presents the request.
   task automatic issue(input logic [15:0] addr, input int lat, input bit gaps);
      exp_t e;
      bit ok;
      int s;
      logic [5:0] t;
      wait_ready(ok);
      if (!ok) return;
      mem_lat  = lat;
      mem_gaps = gaps;
      s = int'(addr[9:4]);
      t = addr[15:10];
      e.addr    = addr;
      e.wr_base = total_wr;
      if (m_v[0][s] && m_t[0][s] == t) begin
         e.hit = 1'b1; e.way = 1'b0;
      end else if (m_v[1][s] && m_t[1][s] == t) begin
         e.hit = 1'b1; e.way = 1'b1;
      end else begin
         e.hit = 1'b0;
         e.way = !m_v[0][s] ? 1'b0 : (!m_v[1][s] ? 1'b1 : m_ptr[s]);
         m_v[e.way][s] = 1'b1;
         m_t[e.way][s] = t;
      end
      m_ptr[s] = (e.way == 1'b0);
      if (e.hit)      e.due = cyc + 2;
      else if (!gaps) e.due = cyc + 11 + lat + int'(e.way);
      else            e.due = -1;
      e.b0 = exp_byte0(s);
      e.b1 = exp_byte1(s);
      sb.push_back(e);
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_addr  = 16'($urandom);
   endtask

   // ---------------- response monitor ----------------
   initial begin
      exp_t e;
      int s;
      logic [15:0] wa;
      forever begin
         @(negedge clk);
         if (rst) check("single_meta_strobe", 1'(bus.meta_write0 && bus.meta_write1), 1'b0);
         if (rst && bus.resp_valid) begin
            if (sb.size() == 0) begin
               check("resp_without_request", bus.resp_valid, 1'b0);
            end else begin
               e = sb.pop_front();
               s = int'(e.addr[9:4]);
               check("resp_hit", bus.resp_hit, e.hit);
               check("resp_way", bus.resp_way, e.way);
               if (e.due >= 0) check("resp_cycle", cyc, e.due);
               @(posedge clk);
               #1;
               check("meta_way0", meta_arr[0][s], e.b0);
               check("meta_way1", meta_arr[1][s], e.b1);
               check("fill_word_count", total_wr - e.wr_base, e.hit ? 0 : 8);
               if (!e.hit) begin
                  for (int w = 0; w < 8; w++) begin
                     wa = {e.addr[15:4], 3'(w), 1'b0};
                     check("fill_data", data_arr[e.way][s][w], mem_fn(wa));
                  end
               end
            end
         end
      end
   end

   // ---------------- reset mid-fill ----------------
   task automatic abort_fill(input logic [15:0] addr);
      bit ok;
      bit v;
      int s, base, guard;
      wait_ready(ok);
      if (!ok) return;
      mem_lat  = 2;
      mem_gaps = 1'b0;
      s = int'(addr[9:4]);
      v = !m_v[0][s] ? 1'b0 : (!m_v[1][s] ? 1'b1 : m_ptr[s]);
      m_v[v][s] = 1'b0;
      m_t[v][s] = '0;
      if (v == 1'b0) m_ptr[s] = 1'b0;
      base = total_wr;
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      @(negedge clk);
      bus.req_valid = 1'b0;
      guard = 0;
      while (total_wr - base < 4 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("abort_reached_return4", total_wr - base, 4);
      rst = 1'b0;
      #1;
      check("reset_outputs_midfill", outs(), RST_OUTS);
      check("abort_victim_meta", meta_arr[v][s], 8'h00);
      check("abort_other_meta", meta_arr[!v][s], v ? exp_byte0(s) : exp_byte1(s));
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int guard;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      #1;
      check("reset_outputs", outs(), RST_OUTS);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      issue(16'h1230, 4, 1'b0);   // cold miss, way 0 filled
      issue(16'h5230, 4, 1'b0);   // same set, way 1 filled, LRU_WR
      issue(16'h5234, 4, 1'b0);   // hit way 1
      issue(16'h1238, 4, 1'b0);   // hit way 0, pointer -> 1
      issue(16'h9230, 4, 1'b0);   // full set, evict way 1
      @(negedge clk);             // cycle 2 of that request
      check("inval_way1", {bus.meta_write0, bus.meta_write1, bus.meta_data_in},
            {1'b0, 1'b1, 8'h00});
      issue(16'hA450, 1, 1'b0);   // latency 1

      for (int n = 0; n < 80; n++) begin
         logic [15:0] a;
         a = {6'($urandom_range(1, 4)), 6'($urandom_range(5, 7)), 4'($urandom)};
         if (n < 40) issue(a, $urandom_range(1, 6), 1'b0);
         else        issue(a, $urandom_range(1, 3), 1'b1);
      end

      abort_fill({6'd9, 6'd40, 4'h0});
      issue({6'd9, 6'd40, 4'h2}, 3, 1'b0);   // must miss again
      issue({6'd9, 6'd40, 4'h4}, 3, 1'b0);   // now hits way 0
      issue({6'd11, 6'd40, 4'h0}, 3, 1'b1);

      guard = 0;
      while (sb.size() != 0 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      check("scoreboard_drained", sb.size(), 0);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cache_meta_ctrl.md
# cache_meta_ctrl

Lookup and miss-fill controller for a 2-way, 64-set cache whose tag metadata is held in a one-byte-per-way metadata array with a shared write-data bus and per-way write strobes. It owns every access to that array. For each request it reads both ways, resolves hit or miss, picks a victim, and streams an 8-word block from memory into the data array. It then writes back tag, valid and replacement state. It sits between the fetch/memory pipeline stage and the cache storage arrays.

## Interface
Parameters (fixed, not overridable):
- SETS, 64, number of sets; index width 6
- WORDS, 8, 16-bit words per block; offset width 4 bytes

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous and active-low
- req_valid  in  1  request present; sampled only when req_ready=1
- req_ready  out  1  high only in IDLE
- req_addr  in  16  byte address: tag=[15:10], index=[9:4], offset=[3:0]
- resp_valid  out  1  one-cycle pulse when the request completes
- resp_hit  out  1  valid with resp_valid; 1 means hit
- resp_way  out  1  way that now holds the block
- meta_block_enable  out  64  one-hot set select = 1<<index; all zero in IDLE
- meta_write0 / meta_write1  out  1  write strobe for way 0 / way 1
- meta_data_in  out  8  shared metadata write byte
- meta_out0 / meta_out1  in  8  way 0 / way 1 read data; high-Z while that way is being written
- mem_en  out  1  memory read request, one word per cycle
- mem_addr  out  16  {tag, index, word[2:0], 1'b0}
- mem_data_valid  in  1  returned word present; returns arrive in request order
- mem_data  in  16  returned word
- data_write  out  1  data-array word write strobe
- data_way  out  1  way being filled
- data_word  out  3  word offset being written
- data_wdata  out  16  equals mem_data

## Operation
- Metadata byte format:
  - bit7 = valid
  - bit6 = victim pointer; meaningful in way 0 only; way 1 always writes 0
  - bits[5:0] = tag
- States: IDLE, LOOKUP, HIT_UPD, INVAL, FILL, META_WR, LRU_WR.
- IDLE:
  - Request accepted when req_valid=1 and req_ready=1.
  - Accepting latches addr and goes to LOOKUP.
- LOOKUP:
  - Block enable is active; no write strobes are asserted.
  - Registers meta_out0 and meta_out1 as m0 and m1.
  - hitN = mN[7] & (mN[5:0]==tag). If both ways hit, way 0 wins.
  - On a hit, go to HIT_UPD.
  - On a miss, choose the victim in this order: way 0 if m0 is invalid; else way 1 if m1 is invalid; else m0[6]. Go to INVAL.
- HIT_UPD:
  - meta_write0=1.
  - Hit in way 0: write {1,1,tag}.
  - Hit in way 1: write {m0[7],0,m0[5:0]}.
  - resp_valid=1, resp_hit=1. Go to IDLE.
- INVAL:
  - Write 8'h00 to the victim way.
  - This prevents a valid old tag from covering a partially overwritten block if reset or an abort occurs mid-fill.
  - Go to FILL.
- FILL:
  - Issue counter req_cnt (3 bits): mem_en=1 for 8 consecutive cycles, word 0..7.
  - Return counter ret_cnt (3 bits): each mem_data_valid writes one data word at data_word=ret_cnt, then increments the counter.
  - Memory latency is not assumed. Requests and returns may overlap.
  - After the 8th return, go to META_WR.
- META_WR:
  - Victim way 0: write {1,1,tag} to way 0 and finish.
  - Victim way 1: write {1,0,tag} to way 1, then go to LRU_WR.
- LRU_WR: write {m0[7],0,m0[5:0]} to way 0.
- Completion of a miss: resp_valid=1 and resp_hit=0 in the final metadata write cycle, then go to IDLE.
- Every cycle:
  - At most one meta_write strobe is high.
  - mem_data_valid outside FILL is ignored.

## Timing
- Reset (async assert): state=IDLE, counters=0.
- Outputs while in reset: all zero except req_ready=1.
- Cycle numbering: request accepted at edge 0.
- Hit: LOOKUP in cycle 1, HIT_UPD in cycle 2, resp_valid in cycle 2.
- Miss with memory latency 4:
  - INVAL in cycle 2.
  - mem_en in cycles 3–10; returns in cycles 7–14.
  - META_WR in cycle 15.
  - resp_valid in cycle 15 (victim way 0) or cycle 16 (victim way 1, via LRU_WR).
- Return and issue in the same cycle are both honoured.
- Reset mid-fill: abort immediately. No metadata write occurs, and the victim stays invalid.

## Structure
- Shared package cache_pkg holds:
  - state enum
  - META_VALID=7, META_LRU=6, tag field [5:0]
  - address field slices
- One natural sub-module: cache_victim_sel, a combinational block mapping (m0, m1) to victim way.

## Test plan
- Cold miss: all metadata 0, addr 0x1230:
  - INVAL, then way 0 filled.
  - Way 0 metadata = {1,1,tag}.
  - resp_hit=0, resp_way=0 in cycle 15.
- Second miss to the same set, different tag:
  - Way 1 filled; way 1 metadata = {1,0,tag}.
  - LRU_WR rewrites way 0 pointer to 0.
  - resp_valid in cycle 16.
- Hit in way 1 after both ways are filled:
  - resp_hit=1 in cycle 2.
  - Way 0 pointer becomes 0; tag and valid unchanged.
- Full set, pointer=1, miss:
  - Way 1 evicted and invalidated in cycle 2.
  - 8 words written in order 0..7.
- Memory latency 1 and random gaps in mem_data_valid:
  - Data words correct.
  - Completion waits for all 8 returns.
- rst low during FILL at return 4:
  - All outputs 0; req_ready=1.
  - Victim metadata remains 8'h00.
